// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: NOP encoding, skid-stage state encoding,
// and channel indices for the IF/ID instance.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam int CH_INSTR = 0;
  localparam int CH_PC    = 1;
  localparam int CH_PC4   = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic logic [1:0] state_occ(input skid_state_e st);
    case (st)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with synchronous clear-to-constant and load enable.
// One cycle latency; no flow control of its own, the owner decides when to load.
module pipe_data_reg #(
  parameter int           W       = 96,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Clear beats load so a flush in the same cycle as a load wins.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_q <= RST_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer: 1-cycle latency, 1 beat/cycle.
// in_ready is a flop (low only when FULL), so there is no path from out_ready to in_ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = XLEN,
  parameter int                NUM_CH    = 3,
  parameter logic [DATA_W-1:0] FLUSH_VAL = DATA_W'(NOP_INSTR)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [1:0]               occupancy
);

  localparam int                BUS_W     = NUM_CH * DATA_W;
  localparam logic [BUS_W-1:0] FLUSH_BUS = {NUM_CH{FLUSH_VAL}};

  skid_state_e      r_state;
  skid_state_e      w_nxt_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_occ;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_clr;
  logic             w_m_load;
  logic             w_s_load;
  logic [BUS_W-1:0] w_m_d;
  logic [BUS_W-1:0] w_m_q;
  logic [BUS_W-1:0] w_s_q;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_clr      = rst | flush;

  always_comb begin
    w_nxt_state = r_state;
    w_m_load    = 1'b0;
    w_s_load    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_nxt_state = ST_ONE;
          w_m_load    = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_m_load = 1'b1;
        end else if (w_in_fire) begin
          w_nxt_state = ST_FULL;
          w_s_load    = 1'b1;
        end else if (w_out_fire) begin
          w_nxt_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the skid-to-main move can happen.
        if (w_out_fire) begin
          w_nxt_state = ST_ONE;
          w_m_load    = 1'b1;
        end
      end
      default: w_nxt_state = ST_EMPTY;
    endcase
  end

  assign w_m_d = (r_state == ST_FULL) ? w_s_q : in_data;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_occ       <= 2'd0;
    end else begin
      r_state     <= w_nxt_state;
      r_out_valid <= (w_nxt_state != ST_EMPTY);
      r_in_ready  <= (w_nxt_state != ST_FULL);
      r_occ       <= state_occ(w_nxt_state);
    end
  end

  pipe_data_reg #(
    .W       (BUS_W),
    .RST_VAL (FLUSH_BUS)
  ) u_main (
    .clk    (clk),
    .i_clr  (w_clr),
    .i_load (w_m_load),
    .i_d    (w_m_d),
    .o_q    (w_m_q)
  );

  pipe_data_reg #(
    .W       (BUS_W),
    .RST_VAL (FLUSH_BUS)
  ) u_skid (
    .clk    (clk),
    .i_clr  (w_clr),
    .i_load (w_s_load),
    .i_d    (in_data),
    .o_q    (w_s_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = w_m_q;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed checks of the default 3x32 stage plus randomised scoreboard runs
// on 1x8 and 4x64 instances.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance: 3 x 32
  logic         a_iv, a_fl, a_or, a_ir, a_ov;
  logic [95:0]  a_id, a_od;
  logic [1:0]   a_occ;
  // 1 x 8
  logic         b_iv, b_fl, b_or, b_ir, b_ov;
  logic [7:0]   b_id, b_od;
  logic [1:0]   b_occ;
  // 4 x 64
  logic         c_iv, c_fl, c_or, c_ir, c_ov;
  logic [255:0] c_id, c_od;
  logic [1:0]   c_occ;

  pipe_skid_stage u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .flush(a_fl), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .occupancy(a_occ)
  );

  pipe_skid_stage #(.DATA_W(8), .NUM_CH(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .flush(b_fl), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .occupancy(b_occ)
  );

  pipe_skid_stage #(.DATA_W(64), .NUM_CH(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .flush(c_fl), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .occupancy(c_occ)
  );

  int n_vec = 0;
  int n_err = 0;

  localparam logic [95:0]  NOP3 = {3{32'h0000_0013}};
  localparam logic [255:0] NOP4 = {4{64'h0000_0000_0000_0013}};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic ov, input logic ir,
                       input logic [1:0] occ, input logic [95:0] od);
    chk({tag, ".out_valid"}, 256'(a_ov), 256'(ov));
    chk({tag, ".in_ready"},  256'(a_ir), 256'(ir));
    chk({tag, ".occupancy"}, 256'(a_occ), 256'(occ));
    chk({tag, ".out_data"},  256'(a_od), 256'(od));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] beat(input logic [31:0] instr, input logic [31:0] pc);
    return {pc + 32'd4, pc, instr};
  endfunction

  task automatic sweep(input int which, input int ncyc);
    logic [255:0] q[$];
    logic [255:0] d;
    logic [255:0] od;
    logic [255:0] mask;
    logic         iv;
    logic         pend;
    logic         ordy;
    logic         ir;
    logic         ov;
    logic [1:0]   occ;
    iv   = 1'b0;
    pend = 1'b0;
    d    = '0;
    mask = (which == 1) ? 256'hFF : {256{1'b1}};
    for (int i = 0; i < ncyc + 8; i++) begin
      if (!pend) begin
        iv = (i < ncyc) && ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        d = d & mask;
      end
      ordy = (i >= ncyc) || ($urandom_range(0, 2) != 0);
      if (which == 1) begin
        b_iv = iv; b_id = d[7:0]; b_or = ordy;
      end else begin
        c_iv = iv; c_id = d; c_or = ordy;
      end
      @(negedge clk);
      if (which == 1) begin
        ir = b_ir; ov = b_ov; occ = b_occ; od = {248'b0, b_od};
      end else begin
        ir = c_ir; ov = c_ov; occ = c_occ; od = c_od;
      end
      chk("sw_occ_le2", 256'(occ <= 2'd2), 256'(1));
      chk("sw_ready_not_full", 256'(ir), 256'(occ != 2'd2));
      chk("sw_valid_occ", 256'(ov), 256'(occ != 2'd0));
      if (ov && ordy) begin
        chk("sw_nonempty", 256'(q.size() != 0), 256'(1));
        if (q.size() != 0) chk("sw_data", od, q.pop_front());
      end
      if (iv && ir) q.push_back(d);
      pend = iv && !ir;
      @(posedge clk);
      #1;
    end
    chk("sw_drained", 256'(q.size()), 256'(0));
    if (which == 1) b_iv = 1'b0; else c_iv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] bA, bB, bC, bD, bE;
    bA = beat(32'h0050_0093, 32'h0000_0100);
    bB = beat(32'h0010_0113, 32'h0000_0104);
    bC = beat(32'h0020_81B3, 32'h0000_0108);
    bD = beat(32'h0030_0213, 32'h0000_010C);
    bE = beat(32'h0040_0293, 32'h0000_0110);

    a_iv = 0; a_fl = 0; a_or = 0; a_id = '0;
    b_iv = 0; b_fl = 0; b_or = 0; b_id = '0;
    c_iv = 0; c_fl = 0; c_or = 0; c_id = '0;

    // Reset
    rst = 1;
    tick(); tick();
    chk_a("rst", 0, 1, 2'd0, NOP3);
    chk("rst_b.out_data", 256'(b_od), 256'(8'h13));
    chk("rst_c.out_data", c_od, NOP4);
    chk("rst_c.in_ready", 256'(c_ir), 256'(1));
    rst = 0;

    // Streaming, no bubbles
    a_or = 1; a_iv = 1; a_id = bA;
    tick(); chk_a("str1", 1, 1, 2'd1, bA);
    a_id = bB;
    tick(); chk_a("str2", 1, 1, 2'd1, bB);
    a_id = bC;
    tick(); chk_a("str3", 1, 1, 2'd1, bC);
    a_iv = 0;
    tick(); chk_a("str_drain", 0, 1, 2'd0, bC);

    // Stall fills the skid entry, then drains in order
    a_or = 0; a_iv = 1; a_id = bA;
    tick(); chk_a("stl1", 1, 1, 2'd1, bA);
    a_id = bB;
    tick(); chk_a("stl2", 1, 0, 2'd2, bA);
    a_id = bC;
    tick(); chk_a("stl3", 1, 0, 2'd2, bA);
    a_or = 1;
    tick(); chk_a("stl4", 1, 1, 2'd1, bB);
    tick(); chk_a("stl5", 1, 1, 2'd1, bC);
    a_iv = 0;
    tick(); chk_a("stl6", 0, 1, 2'd0, bC);

    // Flush while FULL with D offered
    a_or = 0; a_iv = 1; a_id = bA;
    tick(); a_id = bB;
    tick(); chk_a("fl_full", 1, 0, 2'd2, bA);
    a_id = bD; a_fl = 1;
    tick(); a_fl = 0;
    chk_a("fl1", 0, 1, 2'd0, NOP3);
    a_iv = 0; a_or = 1;
    tick(); chk_a("fl2", 0, 1, 2'd0, NOP3);

    // Flush in ONE while a beat fires in and out: both dropped
    a_or = 0; a_iv = 1; a_id = bA;
    tick(); chk_a("flo0", 1, 1, 2'd1, bA);
    a_id = bE; a_fl = 1; a_or = 1;
    tick(); a_fl = 0; a_iv = 0;
    chk_a("flo1", 0, 1, 2'd0, NOP3);
    tick(); chk_a("flo2", 0, 1, 2'd0, NOP3);

    // rst together with flush, from ONE
    a_or = 0; a_iv = 1; a_id = bC;
    tick(); chk_a("rf0", 1, 1, 2'd1, bC);
    rst = 1; a_fl = 1;
    tick(); rst = 0; a_fl = 0; a_iv = 0;
    chk_a("rf1", 0, 1, 2'd0, NOP3);

    // rst while FULL
    a_iv = 1; a_id = bA;
    tick(); a_id = bB;
    tick(); chk_a("rF0", 1, 0, 2'd2, bA);
    rst = 1;
    tick(); rst = 0; a_iv = 0;
    chk_a("rF1", 0, 1, 2'd0, NOP3);

    // Randomised scoreboard runs on the other widths
    sweep(1, 400);
    sweep(2, 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline-stage register, successor to the fixed IF/ID stall/flush register.
- Carries NUM_CH channels of DATA_W bits each, packed into one bus, e.g. instr/PC/PC+4.
- Uses a valid/ready handshake and a 2-entry skid buffer, so upstream ready is a register output with no combinational path from downstream ready.
- Supports flush (bubble insertion) with defined priority; used between any two RISC-V pipeline stages.

Parameters:
- DATA_W, 32, width of one channel.
- NUM_CH, 3, number of channels; bus width = NUM_CH*DATA_W.
- FLUSH_VAL, 32'h0000_0013, per-channel value driven on out_data while empty or after flush/reset (NOP encoding).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid beat.
- in_ready  out  1  stage can accept a beat this cycle; registered.
- in_data  in  NUM_CH*DATA_W  packed channels; channel k = bits [k*DATA_W +: DATA_W].
- flush  in  1  discard all held beats plus any beat offered this cycle.
- out_valid  out  1  main entry holds a valid beat.
- out_ready  in  1  downstream accepts; low = stall.
- out_data  out  NUM_CH*DATA_W  main-entry payload.
- occupancy  out  2  beats held: 0, 1 or 2.

Behaviour:
- Storage: main entry (m_valid, m_data) and skid entry (s_valid, s_data).
- Outputs: out_valid = m_valid; out_data = m_data; in_ready = !s_valid, registered; occupancy = m_valid + s_valid.
- Transfers: in_fire = in_valid & in_ready; out_fire = m_valid & out_ready.
- States:
  - EMPTY: m=0, s=0.
  - ONE: m=1, s=0.
  - FULL: m=1, s=1.
- Transitions, all at posedge, no flush, no rst:
  - EMPTY, in_fire -> ONE; m_data <= in_data.
  - ONE, in_fire & out_fire -> ONE; m_data <= in_data.
  - ONE, in_fire & !out_fire -> FULL; s_data <= in_data.
  - ONE, !in_fire & out_fire -> EMPTY.
  - FULL, out_fire -> ONE; m_data <= s_data. in_ready is 0 in FULL, so no input is accepted.
  - Otherwise hold; data registers are not written.
- Latency: 1 cycle in_fire -> out_valid when EMPTY. Throughput 1 beat/cycle while out_ready=1.
- Ordering: strict FIFO; the skid beat always exits after the main beat.
- Flush, priority below rst, above everything else:
  - Next state EMPTY; m_data and s_data <= {NUM_CH{FLUSH_VAL}}.
  - A beat offered with in_fire in the flush cycle is dropped.
  - out_fire in the flush cycle still counts as consumed by downstream.
  - in_ready = 1 the following cycle.
- Reset: rst=1 at posedge -> EMPTY. out_valid=0, in_ready=1, occupancy=0, out_data={NUM_CH{FLUSH_VAL}}. Mid-operation reset discards held beats identically to flush.
- Data on out_data while out_valid=0 is FLUSH_VAL after reset/flush. After a drain to EMPTY it keeps the last beat; downstream must qualify with out_valid.
- Protocol rules:
  - Upstream must hold in_data stable while in_valid & !in_ready.
  - The stage holds out_data stable while out_valid & !out_ready.
  - in_ready never depends combinationally on out_ready.
- Legacy mapping for existing stages: en = out_ready, clr = flush, in_valid tied 1.

Decomposition:
- Shared package pipe_pkg:
  - localparams NOP_INSTR = 32'h0000_0013 and XLEN = 32.
  - State encoding EMPTY/ONE/FULL.
  - Channel-index constants for the IF/ID instance: CH_INSTR=0, CH_PC=1, CH_PC4=2.
- One natural sub-module, pipe_data_reg: NUM_CH*DATA_W register with synchronous load/reset-value. Instantiated twice, for main and skid; the control FSM stays in pipe_skid_stage.

Test Plan:
- Reset: rst=1 for 2 cycles -> out_valid=0, in_ready=1, occupancy=0, out_data=three copies of 32'h13.
- Streaming: out_ready=1, send beats A=0x00500093, B=0x00100113, C=0x002081B3 on consecutive cycles -> each appears on out_data exactly 1 cycle later, occupancy stays 1, no bubbles.
- Stall/skid:
  - Hold out_ready=0 while sending A then B -> occupancy 1 then 2; in_ready falls the cycle after B is accepted; a third beat C is held upstream, not accepted.
  - Raise out_ready -> A, B, C emitted in order, no loss or duplication.
- Flush in FULL with in_valid=1 offering D -> next cycle occupancy=0, out_valid=0, out_data=FLUSH_VAL; D never appears on the output.
- Simultaneous flush + rst: rst wins, giving the reset state. Also: rst asserted while FULL -> EMPTY next cycle, in_ready=1.
- Parameter sweep: NUM_CH=1, DATA_W=8 and NUM_CH=4, DATA_W=64 with randomised valid/ready against a scoreboard FIFO -> output order equals input order, occupancy ≤ 2, in_ready deasserted only in FULL.
